// File: rtl/udp_rx_pkg.sv
// Shared definitions for the UDP receive-side dispatcher.
package udp_rx_pkg;

  localparam int unsigned NCH_DEF = 4;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StPass = 2'd2,
    StDrop = 2'd3
  } rx_state_e;

  // Saturating increment; counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/udp_port_dispatch_if.sv
// Payload stream from the UDP unpacker into the dispatcher.
interface udp_port_dispatch_if;

  logic [15:0] des_port;
  logic        udp_pkt_start;
  logic        udp_pkt_en;
  logic [7:0]  udp_pkt_dat;
  logic        udp_pkt_end;

  modport master (
    output des_port,
    output udp_pkt_start,
    output udp_pkt_en,
    output udp_pkt_dat,
    output udp_pkt_end
  );

  modport slave (
    input des_port,
    input udp_pkt_start,
    input udp_pkt_en,
    input udp_pkt_dat,
    input udp_pkt_end
  );

endinterface

// File: rtl/udp_port_match.sv
// Bind table plus lowest-index-wins port lookup.
module udp_port_match
  import udp_rx_pkg::*;
#(
  parameter int unsigned NCH  = NCH_DEF,
  parameter int unsigned IDXW = $clog2(NCH)
) (
  input  logic            rx_clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_idx,
  input  logic [15:0]     cfg_port,
  input  logic            cfg_valid,
  input  logic [15:0]     des_port,
  output logic            hit,
  output logic [IDXW-1:0] hit_idx
);

  logic [15:0] port_q  [NCH];
  logic        valid_q [NCH];

  // Table write; lookups in the write cycle still see the old entry.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        port_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_we && (cfg_idx == IDXW'(i))) begin
          port_q[i]  <= cfg_port;
          valid_q[i] <= cfg_valid;
        end
      end
    end
  end

  // Priority encode: scan high to low so the lowest matching index is left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (valid_q[i] && (port_q[i] == des_port)) begin
        hit     = 1'b1;
        hit_idx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/udp_port_dispatch.sv
// Steers each UDP payload to the consumer channel bound to its destination port.
module udp_port_dispatch
  import udp_rx_pkg::*;
#(
  parameter int unsigned NCH  = NCH_DEF,
  parameter int unsigned IDXW = $clog2(NCH)
) (
  input  logic               rx_clk,
  input  logic               rst_n,
  udp_port_dispatch_if.slave rx,
  input  logic               cfg_we,
  input  logic [IDXW-1:0]    cfg_idx,
  input  logic [15:0]        cfg_port,
  input  logic               cfg_valid,
  output logic [NCH-1:0]     ch_pkt_start,
  output logic [NCH-1:0]     ch_pkt_en,
  output logic [7:0]         ch_pkt_dat,
  output logic [NCH-1:0]     ch_pkt_end,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic [CNT_W-1:0]   pass_cnt
);

  rx_state_e         state_q;
  logic [IDXW-1:0]   ch_q;
  logic [NCH-1:0]    start_q, en_q, end_q;
  logic [7:0]        dat_q;
  logic [CNT_W-1:0]  drop_cnt_q, pass_cnt_q;
  logic              hit;
  logic [IDXW-1:0]   hit_idx;

  function automatic logic [NCH-1:0] to_onehot(input logic [IDXW-1:0] idx);
    logic [NCH-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  udp_port_match #(
    .NCH  (NCH),
    .IDXW (IDXW)
  ) u_match (
    .rx_clk    (rx_clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_port  (cfg_port),
    .cfg_valid (cfg_valid),
    .des_port  (rx.des_port),
    .hit       (hit),
    .hit_idx   (hit_idx)
  );

  // Packet FSM with registered channel outputs and counters.
  // A start seen before end closes the old packet as truncated (no pass credit).
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      start_q    <= '0;
      en_q       <= '0;
      end_q      <= '0;
      dat_q      <= '0;
      drop_cnt_q <= '0;
      pass_cnt_q <= '0;
    end else begin
      start_q <= '0;
      en_q    <= '0;
      end_q   <= '0;
      dat_q   <= '0;
      unique case (state_q)
        StIdle: begin
          if (rx.udp_pkt_start) state_q <= StWait;
        end
        StWait: begin
          if (rx.udp_pkt_en && hit) begin
            ch_q    <= hit_idx;
            start_q <= to_onehot(hit_idx);
            en_q    <= to_onehot(hit_idx);
            dat_q   <= rx.udp_pkt_dat;
          end
          if (rx.udp_pkt_end || rx.udp_pkt_start) begin
            if (rx.udp_pkt_en && hit) begin
              end_q <= to_onehot(hit_idx);
              if (rx.udp_pkt_end) pass_cnt_q <= sat_inc(pass_cnt_q);
            end else begin
              drop_cnt_q <= sat_inc(drop_cnt_q);
            end
            state_q <= rx.udp_pkt_start ? StWait : StIdle;
          end else if (rx.udp_pkt_en) begin
            state_q <= hit ? StPass : StDrop;
          end
        end
        StPass: begin
          if (rx.udp_pkt_en) begin
            en_q  <= to_onehot(ch_q);
            dat_q <= rx.udp_pkt_dat;
          end
          if (rx.udp_pkt_end || rx.udp_pkt_start) begin
            end_q <= to_onehot(ch_q);
            if (rx.udp_pkt_end) pass_cnt_q <= sat_inc(pass_cnt_q);
            state_q <= rx.udp_pkt_start ? StWait : StIdle;
          end
        end
        StDrop: begin
          if (rx.udp_pkt_end || rx.udp_pkt_start) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
            state_q    <= rx.udp_pkt_start ? StWait : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ch_pkt_start = start_q;
  assign ch_pkt_en    = en_q;
  assign ch_pkt_end   = end_q;
  assign ch_pkt_dat   = dat_q;
  assign drop_cnt     = drop_cnt_q;
  assign pass_cnt     = pass_cnt_q;

endmodule

// File: tb/tb_udp_port_dispatch.sv
// Bench for udp_port_dispatch: packet-level reference model plus cycle monitor.
module tb_udp_port_dispatch;

  localparam int NCH = 4;
  typedef logic [7:0] byte_q_t[$];

  logic            rx_clk = 1'b0;
  logic            rst_n  = 1'b0;
  logic            cfg_we = 1'b0;
  logic [1:0]      cfg_idx = '0;
  logic [15:0]     cfg_port = '0;
  logic            cfg_valid = 1'b0;
  logic [NCH-1:0]  ch_pkt_start, ch_pkt_en, ch_pkt_end;
  logic [7:0]      ch_pkt_dat;
  logic [15:0]     drop_cnt, pass_cnt;

  udp_port_dispatch_if rx_if ();

  udp_port_dispatch #(
    .NCH  (NCH),
    .IDXW (2)
  ) dut (
    .rx_clk       (rx_clk),
    .rst_n        (rst_n),
    .rx           (rx_if),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_port     (cfg_port),
    .cfg_valid    (cfg_valid),
    .ch_pkt_start (ch_pkt_start),
    .ch_pkt_en    (ch_pkt_en),
    .ch_pkt_dat   (ch_pkt_dat),
    .ch_pkt_end   (ch_pkt_end),
    .drop_cnt     (drop_cnt),
    .pass_cnt     (pass_cnt)
  );

  always #4 rx_clk = ~rx_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: bind table, counters, currently open packet.
  logic [15:0] m_port [NCH];
  bit          m_valid[NCH];
  logic [15:0] m_pass = '0, m_drop = '0;
  bit          pkt_open = 0, pkt_routed = 0;
  int          pkt_dest = -1;

  // Expected outputs for the inputs just driven, and the copy due at the outputs now.
  logic [NCH-1:0] exp_start = '0, exp_en = '0, exp_end = '0;
  logic [7:0]     exp_dat = '0;
  logic [15:0]    exp_pass = '0, exp_drop = '0;
  logic [NCH-1:0] e1_start = '0, e1_en = '0, e1_end = '0;
  logic [7:0]     e1_dat = '0;
  logic [15:0]    e1_pass = '0, e1_drop = '0;

  // Monitor results.
  int    mon_bad = 0;
  string mon_last = "";
  int    cap[$];
  int    starts[NCH];
  int    ends[NCH];

  logic [15:0] ports[6] = '{16'd5000, 16'd53, 16'd80, 16'd6000, 16'd7777, 16'd4242};

  always @(posedge rx_clk) begin
    e1_start <= exp_start; e1_en <= exp_en; e1_end <= exp_end;
    e1_dat <= exp_dat; e1_pass <= exp_pass; e1_drop <= exp_drop;
  end

  always @(negedge rx_clk) begin
    if ({ch_pkt_start, ch_pkt_en, ch_pkt_end, ch_pkt_dat, pass_cnt, drop_cnt} !==
        {e1_start, e1_en, e1_end, e1_dat, e1_pass, e1_drop}) begin
      mon_bad++;
      mon_last = $sformatf("st=%b/%b en=%b/%b end=%b/%b dat=%h/%h pass=%h/%h drop=%h/%h",
                           ch_pkt_start, e1_start, ch_pkt_en, e1_en, ch_pkt_end, e1_end,
                           ch_pkt_dat, e1_dat, pass_cnt, e1_pass, drop_cnt, e1_drop);
    end
    for (int k = 0; k < NCH; k++) begin
      if (ch_pkt_en[k]) cap.push_back(k * 256 + int'(ch_pkt_dat));
      starts[k] += int'(ch_pkt_start[k]);
      ends[k]   += int'(ch_pkt_end[k]);
    end
  end

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic int lookup(input logic [15:0] p);
    for (int k = 0; k < NCH; k++) if (m_valid[k] && m_port[k] == p) return k;
    return -1;
  endfunction

  task automatic drive(input bit s, input bit e, input logic [7:0] d, input bit fin,
                       input logic [15:0] p, input bit we, input int widx,
                       input logic [15:0] wport, input bit wvalid);
    @(negedge rx_clk); #1;
    rx_if.udp_pkt_start = s;
    rx_if.udp_pkt_en    = e;
    rx_if.udp_pkt_dat   = d;
    rx_if.udp_pkt_end   = fin;
    rx_if.des_port      = p;
    cfg_we = we; cfg_idx = 2'(widx); cfg_port = wport; cfg_valid = wvalid;
    exp_start = '0; exp_en = '0; exp_end = '0; exp_dat = '0;
    if (e && pkt_open) begin
      if (!pkt_routed) begin
        pkt_routed = 1;
        pkt_dest   = lookup(p);
        if (pkt_dest >= 0) exp_start[pkt_dest] = 1'b1;
      end
      if (pkt_dest >= 0) begin
        exp_en[pkt_dest] = 1'b1;
        exp_dat          = d;
      end
    end
    if (pkt_open && (fin || s)) begin
      if (pkt_routed && pkt_dest >= 0) begin
        exp_end[pkt_dest] = 1'b1;
        if (fin) m_pass = sat(m_pass);
      end else begin
        m_drop = sat(m_drop);
      end
      pkt_open = 0;
    end
    if (s) begin
      pkt_open = 1; pkt_routed = 0; pkt_dest = -1;
    end
    if (we) begin
      m_port[widx]  = wport;
      m_valid[widx] = wvalid;
    end
    exp_pass = m_pass;
    exp_drop = m_drop;
  endtask

  task automatic step(input bit s, input bit e, input logic [7:0] d, input bit fin,
                      input logic [15:0] p);
    drive(s, e, e ? d : 8'($urandom), fin, p, 0, 0, 16'd0, 0);
  endtask

  task automatic cfg_write(input int idx, input logic [15:0] p, input bit v);
    drive(0, 0, 8'($urandom), 0, rx_if.des_port, 1, idx, p, v);
  endtask

  task automatic send_pkt(input logic [15:0] p, input byte_q_t b, input bit gaps,
                          input bit close);
    step(1, 0, 8'h00, 0, p);
    foreach (b[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) step(0, 0, 8'h00, 0, p);
      step(0, 1, b[i], 0, p);
    end
    if (close) step(0, 0, 8'h00, 1, p);
  endtask

  task automatic flush();
    repeat (3) step(0, 0, 8'h00, 0, rx_if.des_port);
  endtask

  task automatic clear_mon();
    mon_bad = 0;
    cap.delete();
    for (int k = 0; k < NCH; k++) begin starts[k] = 0; ends[k] = 0; end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin m_port[k] = '0; m_valid[k] = 0; end
    m_pass = '0; m_drop = '0; pkt_open = 0; pkt_routed = 0; pkt_dest = -1;
    exp_start = '0; exp_en = '0; exp_end = '0; exp_dat = '0; exp_pass = '0; exp_drop = '0;
  endtask

  task automatic check_stream(input string name, input int exp_q[$]);
    vectors++;
    if (mon_bad !== 0) begin
      miscompares++;
      $display("FAIL %s cycle: %0d bad cycles, got/want %s", name, mon_bad, mon_last);
    end
    vectors++;
    if (cap.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL %s bytes: got %0d bytes, want %0d", name, cap.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        if (cap[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL %s byte%0d: got ch%0d:%h want ch%0d:%h", name, i, cap[i] / 256,
                   cap[i] % 256, exp_q[i] / 256, exp_q[i] % 256);
        end
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    rx_if.udp_pkt_start = 0; rx_if.udp_pkt_en = 0; rx_if.udp_pkt_end = 0;
    rx_if.udp_pkt_dat = '0; rx_if.des_port = '0;
    repeat (2) @(negedge rx_clk);
    vectors++;
    if ({ch_pkt_start, ch_pkt_en, ch_pkt_end} !== '0) begin
      miscompares++;
      $display("FAIL reset_ch: got %b want 0", {ch_pkt_start, ch_pkt_en, ch_pkt_end});
    end
    vectors++;
    if (ch_pkt_dat !== 8'h00) begin
      miscompares++; $display("FAIL reset_dat: got %h want 00", ch_pkt_dat);
    end
    vectors++;
    if ({pass_cnt, drop_cnt} !== 32'h0) begin
      miscompares++; $display("FAIL reset_cnt: got %h/%h want 0/0", pass_cnt, drop_cnt);
    end
    #1 rst_n = 1'b1;
    clear_mon();
  endtask

  // Bind 5000 on ch0; 4-byte packet delivered on ch0 with 1-cycle latency.
  task automatic test_basic();
    byte_q_t b;
    int e_q[$];
    clear_mon();
    cfg_write(0, 16'd5000, 1);
    b = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_pkt(16'd5000, b, 0, 1);
    flush();
    e_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    check_stream("basic", e_q);
    vectors++;
    if (starts[0] !== 1 || ends[0] !== 1) begin
      miscompares++; $display("FAIL basic_pulses: got %0d/%0d want 1/1", starts[0], ends[0]);
    end
    vectors++;
    if (pass_cnt !== 16'd1) begin
      miscompares++; $display("FAIL basic_pass: got %0d want 1", pass_cnt);
    end
  endtask

  // Duplicate binding resolves to the lowest index; unbound port dropped.
  task automatic test_dup();
    byte_q_t b;
    int e_q[$];
    logic [15:0] d0;
    clear_mon();
    d0 = drop_cnt;
    cfg_write(1, 16'd53, 1);
    cfg_write(2, 16'd53, 1);
    b = {8'($urandom), 8'($urandom), 8'($urandom)};
    send_pkt(16'd53, b, 1, 1);
    send_pkt(16'd80, b, 1, 1);
    flush();
    foreach (b[i]) e_q.push_back(256 + int'(b[i]));
    check_stream("dup", e_q);
    vectors++;
    if (starts[1] !== 1 || starts[2] !== 0 || ends[2] !== 0) begin
      miscompares++;
      $display("FAIL dup_ch2: got st1=%0d st2=%0d end2=%0d want 1/0/0",
               starts[1], starts[2], ends[2]);
    end
    vectors++;
    if (drop_cnt !== d0 + 16'd1) begin
      miscompares++; $display("FAIL dup_drop: got %0d want %0d", drop_cnt, d0 + 16'd1);
    end
  endtask

  // Rebinding mid-packet leaves the in-flight packet on its channel.
  task automatic test_reprogram();
    int e_q[$];
    logic [15:0] d0;
    clear_mon();
    d0 = drop_cnt;
    step(1, 0, 8'h00, 0, 16'd5000);
    step(0, 1, 8'h01, 0, 16'd5000);
    drive(0, 1, 8'h02, 0, 16'd5000, 1, 0, 16'd6000, 1);
    step(0, 1, 8'h03, 0, 16'd5000);
    step(0, 0, 8'h00, 1, 16'd5000);
    send_pkt(16'd5000, {8'h04, 8'h05}, 0, 1);
    flush();
    e_q = {1, 2, 3};
    check_stream("reprog", e_q);
    vectors++;
    if (drop_cnt !== d0 + 16'd1) begin
      miscompares++; $display("FAIL reprog_drop: got %0d want %0d", drop_cnt, d0 + 16'd1);
    end
  endtask

  // New start after two bytes on ch3: truncation end pulse, no pass credit.
  task automatic test_truncate();
    int e_q[$];
    logic [15:0] p0;
    clear_mon();
    p0 = pass_cnt;
    cfg_write(3, 16'd7777, 1);
    send_pkt(16'd7777, {8'h11, 8'h22}, 0, 0);
    send_pkt(16'd6000, {8'h33, 8'h44, 8'h55}, 1, 1);
    flush();
    e_q = {3 * 256 + 8'h11, 3 * 256 + 8'h22, 8'h33, 8'h44, 8'h55};
    check_stream("trunc", e_q);
    vectors++;
    if (ends[3] !== 1 || ends[0] !== 1) begin
      miscompares++; $display("FAIL trunc_end: got %0d/%0d want 1/1", ends[3], ends[0]);
    end
    vectors++;
    if (pass_cnt !== p0 + 16'd1) begin
      miscompares++; $display("FAIL trunc_pass: got %0d want %0d", pass_cnt, p0 + 16'd1);
    end
  endtask

  // Random packets, gaps, binds, truncations and end+start overlap.
  task automatic test_random();
    int prev_mode = 0;
    int mode, n;
    logic [15:0] p;
    clear_mon();
    for (int i = 0; i < 80; i++) begin
      p    = ports[$urandom_range(0, 5)];
      n    = $urandom_range(0, 5);
      mode = (i == 79) ? 0 : $urandom_range(0, 3);
      if (prev_mode < 2 && $urandom_range(0, 3) == 0)
        cfg_write($urandom_range(0, 3), ports[$urandom_range(0, 5)], 1'($urandom));
      step(1, 0, 8'h00, prev_mode == 2, p);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 2) == 0) step(0, 0, 8'h00, 0, p);
        if ($urandom_range(0, 5) == 0)
          drive(0, 1, 8'($urandom), 0, p, 1, $urandom_range(0, 3),
                ports[$urandom_range(0, 5)], 1'($urandom));
        else
          step(0, 1, 8'($urandom), 0, p);
      end
      if (mode < 2) step(0, 0, 8'h00, 1, p);
      if (mode == 1) step(0, 0, 8'h00, 0, p);
      prev_mode = mode;
    end
    flush();
    vectors++;
    if (mon_bad !== 0) begin
      miscompares++;
      $display("FAIL random cycle: %0d bad cycles, got/want %s", mon_bad, mon_last);
    end
    vectors++;
    if (pass_cnt !== m_pass || drop_cnt !== m_drop) begin
      miscompares++;
      $display("FAIL random_cnt: got %0d/%0d want %0d/%0d", pass_cnt, drop_cnt, m_pass, m_drop);
    end
  endtask

  // Drop counter preset to FFFE, three unbound packets must stick at FFFF.
  task automatic test_saturate();
    clear_mon();
    @(negedge rx_clk); #1;
    force dut.drop_cnt_q = 16'hFFFE;
    m_drop   = 16'hFFFE;
    exp_drop = 16'hFFFE;
    step(0, 0, 8'h00, 0, 16'd1234);
    release dut.drop_cnt_q;
    for (int i = 0; i < 3; i++) send_pkt(16'd1234, {8'($urandom)}, 0, 1);
    flush();
    vectors++;
    if (drop_cnt !== 16'hFFFF) begin
      miscompares++; $display("FAIL sat_drop: got %h want FFFF", drop_cnt);
    end
    vectors++;
    if (mon_bad !== 0) begin
      miscompares++; $display("FAIL sat cycle: %0d bad cycles, got/want %s", mon_bad, mon_last);
    end
  endtask

  // Reset mid-PASS clears outputs at once; table comes back empty.
  task automatic test_reset_mid();
    int e_q[$];
    cfg_write(0, 16'd5000, 1);
    send_pkt(16'd5000, {8'h61, 8'h62}, 0, 0);
    @(negedge rx_clk); #1;
    rst_n = 1'b0;
    rx_if.udp_pkt_start = 0; rx_if.udp_pkt_en = 0; rx_if.udp_pkt_end = 0;
    cfg_we = 0;
    model_reset();
    #1;
    vectors++;
    if ({ch_pkt_start, ch_pkt_en, ch_pkt_end, ch_pkt_dat} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_ch: got en=%b dat=%h want 0", ch_pkt_en, ch_pkt_dat);
    end
    vectors++;
    if ({pass_cnt, drop_cnt} !== 32'h0) begin
      miscompares++; $display("FAIL rstmid_cnt: got %h/%h want 0/0", pass_cnt, drop_cnt);
    end
    @(negedge rx_clk); #1;
    rst_n = 1'b1;
    clear_mon();
    step(0, 1, 8'h63, 0, 16'd5000);
    step(0, 0, 8'h00, 1, 16'd5000);
    send_pkt(16'd5000, {8'h71, 8'h72}, 0, 1);
    flush();
    check_stream("rstmid", e_q);
    vectors++;
    if (drop_cnt !== 16'd1 || pass_cnt !== 16'd0) begin
      miscompares++; $display("FAIL rstmid_after: got %0d/%0d want 1/0", drop_cnt, pass_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dup();
    test_reprogram();
    test_truncate();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
